wb_port_arb: RTL and testbench



---
 rtl/wb_port_arb.sv | 166 ++++++++++++++++
 tb/tb_wb_port_arb.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results drain from a FIFO.
// Define WB_ARB_STARVE_EN to enable the starvation guard that forces one drain slot after STARVE_LIMIT waits.
module wb_port_arb #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_wen_i,
  input  logic [4:0]               pipe_waddr_i,
  input  logic [63:0]              pipe_wdata_i,
  input  logic                     lq_valid_i,
  output logic                     lq_ready_o,
  input  logic [4:0]               lq_waddr_i,
  input  logic [63:0]              lq_wdata_i,
  output logic                     pipe_stall_o,
  output logic                     reg_wen_o,
  output logic [4:0]               reg_waddr_o,
  output logic [63:0]              reg_wdata_o,
  output logic [$clog2(DEPTH):0]   lq_count_o,
  output logic                     lq_pending_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("wb_port_arb: DEPTH must be a power of 2 and >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_limit_chk
    $error("wb_port_arb: STARVE_LIMIT must be >= 1");
  end

  typedef struct packed {
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        killed;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  entry_t          fifo_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            pipe_grant;
  logic            force_pop;
  entry_t          head;

  assign fifo_empty   = (count_q == '0);
  // Ready depends only on the registered count so a same-cycle pop never opens a slot.
  assign lq_ready_o   = !rst && (count_q < CW'(DEPTH));
  assign push         = lq_valid_i && lq_ready_o;
  assign head         = fifo_q[rd_ptr_q];
  assign lq_count_o   = rst ? '0 : count_q;
  assign lq_pending_o = !rst && !fifo_empty;

`ifdef WB_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  typedef enum logic {NORMAL, FORCE} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;

  assign force_pop    = (state_q == FORCE);
  assign pipe_stall_o = !rst && force_pop;

  always_comb begin
    state_d  = NORMAL;
    starve_d = '0;
    if (!force_pop && !fifo_empty && !pop) begin
      starve_d = starve_q + 1'b1;
      if (starve_q == SW'(STARVE_LIMIT - 1)) begin
        state_d  = FORCE;
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
`else
  assign force_pop    = 1'b0;
  assign pipe_stall_o = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    pipe_grant  = 1'b0;
    pop         = 1'b0;
    reg_wen_o   = 1'b0;
    reg_waddr_o = '0;
    reg_wdata_o = '0;
    if (!rst) begin
      if (force_pop) begin
        pop         = !fifo_empty;
        reg_wen_o   = !fifo_empty && !head.killed;
        reg_waddr_o = head.waddr;
        reg_wdata_o = head.wdata;
      end else if (pipe_wen_i && pipe_waddr_i != 5'd0) begin
        pipe_grant  = 1'b1;
        reg_wen_o   = 1'b1;
        reg_waddr_o = pipe_waddr_i;
        reg_wdata_o = pipe_wdata_i;
      end else if (!fifo_empty) begin
        pop         = 1'b1;
        reg_wen_o   = !head.killed;
        reg_waddr_o = head.waddr;
        reg_wdata_o = head.wdata;
      end
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // A granted pipeline write makes every older queued result for the same register stale.
    if (pipe_grant) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_q[i].waddr == pipe_waddr_i) fifo_d[i].killed = 1'b1;
      end
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) begin
      fifo_d[wr_ptr_q] = '{waddr: lq_waddr_i, wdata: lq_wdata_i, killed: (lq_waddr_i == 5'd0)};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; an entry is only observed after a push has written it.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_wb_port_arb.sv
// Self-checking bench for wb_port_arb: queue/register-file model compared every cycle plus directed literal checks.
module tb_wb_port_arb;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic                   clk;
  logic                   rst;
  logic                   pipe_wen_i;
  logic [4:0]             pipe_waddr_i;
  logic [63:0]            pipe_wdata_i;
  logic                   lq_valid_i;
  logic                   lq_ready_o;
  logic [4:0]             lq_waddr_i;
  logic [63:0]            lq_wdata_i;
  logic                   pipe_stall_o;
  logic                   reg_wen_o;
  logic [4:0]             reg_waddr_o;
  logic [63:0]            reg_wdata_o;
  logic [$clog2(DEPTH):0] lq_count_o;
  logic                   lq_pending_o;

  wb_port_arb #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_wen_i   (pipe_wen_i),
    .pipe_waddr_i (pipe_waddr_i),
    .pipe_wdata_i (pipe_wdata_i),
    .lq_valid_i   (lq_valid_i),
    .lq_ready_o   (lq_ready_o),
    .lq_waddr_i   (lq_waddr_i),
    .lq_wdata_i   (lq_wdata_i),
    .pipe_stall_o (pipe_stall_o),
    .reg_wen_o    (reg_wen_o),
    .reg_waddr_o  (reg_waddr_o),
    .reg_wdata_o  (reg_wdata_o),
    .lq_count_o   (lq_count_o),
    .lq_pending_o (lq_pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Model: queued results in arrival order, plus the register file as observed at the DUT port.
  typedef struct {
    bit [4:0]  a;
    bit [63:0] d;
    bit        k;
  } ent_t;

  ent_t      mq[$];
  bit        m_force = 0;
  int        m_wait  = 0;
  bit [63:0] dut_rf [32];

  initial begin
    for (int i = 0; i < 32; i++) dut_rf[i] = '0;
  end

  always @(negedge clk) begin
    bit        m_pipe, m_pop, m_push, m_had, e_wen, e_ready, e_stall;
    bit [4:0]  e_a;
    bit [63:0] e_d;
    e_ready = !rst && (mq.size() < DEPTH);
    check("cmp_lq_ready", lq_ready_o, e_ready);
    check("cmp_lq_count", lq_count_o, rst ? 0 : mq.size());
    check("cmp_lq_pending", lq_pending_o, !rst && mq.size() != 0);
    if (rst) begin
      check("cmp_rst_wen", reg_wen_o, 0);
      check("cmp_rst_stall", pipe_stall_o, 0);
      mq.delete();
      m_force = 0;
      m_wait  = 0;
    end else begin
      m_pipe = 0; m_pop = 0; e_wen = 0; e_a = 0; e_d = 0;
      e_stall = m_force;
      if (m_force && mq.size() != 0) begin
        m_pop = 1; e_wen = !mq[0].k; e_a = mq[0].a; e_d = mq[0].d;
      end else if (!m_force && pipe_wen_i && pipe_waddr_i != 0) begin
        m_pipe = 1; e_wen = 1; e_a = pipe_waddr_i; e_d = pipe_wdata_i;
      end else if (!m_force && mq.size() != 0) begin
        m_pop = 1; e_wen = !mq[0].k; e_a = mq[0].a; e_d = mq[0].d;
      end
      check("cmp_reg_wen", reg_wen_o, e_wen);
      check("cmp_reg_waddr", reg_waddr_o, e_a);
      check("cmp_reg_wdata", reg_wdata_o, e_d);
      check("cmp_pipe_stall", pipe_stall_o, e_stall);
      if (reg_wen_o) dut_rf[reg_waddr_o] = reg_wdata_o;
      m_push = e_ready && lq_valid_i;
      m_had  = mq.size() != 0;
      if (m_pipe) foreach (mq[i]) if (mq[i].a == pipe_waddr_i) mq[i].k = 1;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{lq_waddr_i, lq_wdata_i, lq_waddr_i == 0});
`ifdef WB_ARB_STARVE_EN
      if (m_force) begin
        m_force = 0;
        m_wait  = 0;
      end else if (m_had && !m_pop) begin
        m_wait++;
        if (m_wait == STARVE_LIMIT) begin
          m_force = 1;
          m_wait  = 0;
        end
      end else begin
        m_wait = 0;
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_pipe(input bit w, input bit [4:0] a, input bit [63:0] d);
    pipe_wen_i = w; pipe_waddr_i = a; pipe_wdata_i = d;
  endtask

  task automatic drive_lq(input bit v, input bit [4:0] a, input bit [63:0] d);
    lq_valid_i = v; lq_waddr_i = a; lq_wdata_i = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_stall;
    int stall_cycles;
    bit drained;

    rst = 1'b1;
    drive_pipe(0, 0, 0);
    drive_lq(1, 5'd4, 64'h99);
    sample();
    check("rst_ready", lq_ready_o, 0);
    check("rst_count", lq_count_o, 0);
    check("rst_wen", reg_wen_o, 0);
    check("rst_stall", pipe_stall_o, 0);
    tick();
    sample();
    check("rst_ready2", lq_ready_o, 0);
    tick();
    rst = 1'b0;
    drive_lq(0, 0, 0);
    sample();
    check("post_rst_ready", lq_ready_o, 1);
    check("post_rst_count", lq_count_o, 0);
    tick();

    // Idle drain
    drive_lq(1, 5'd5, 64'h1234);
    sample();
    tick();
    drive_lq(0, 0, 0);
    sample();
    check("drain_count1", lq_count_o, 1);
    check("drain_wen", reg_wen_o, 1);
    check("drain_waddr", reg_waddr_o, 5);
    check("drain_wdata", reg_wdata_o, 64'h1234);
    tick();
    sample();
    check("drain_count0", lq_count_o, 0);
    tick();

    // Pipeline priority
    drive_pipe(1, 5'd3, 64'h11);
    drive_lq(1, 5'd7, 64'h22);
    sample();
    check("prio_waddr0", reg_waddr_o, 3);
    tick();
    drive_lq(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sample();
      check("prio_waddr", reg_waddr_o, 3);
      check("prio_count", lq_count_o, 1);
      tick();
    end
    drive_pipe(0, 0, 0);
    sample();
    check("prio_lq_wen", reg_wen_o, 1);
    check("prio_lq_waddr", reg_waddr_o, 7);
    check("prio_lq_wdata", reg_wdata_o, 64'h22);
    tick();
    sample();
    check("prio_count0", lq_count_o, 0);
    tick();

    // Kill of a stale queued result, and a push to x0
    drive_pipe(1, 5'd1, 64'h1);
    drive_lq(1, 5'd9, 64'hAA);
    sample();
    tick();
    drive_lq(0, 0, 0);
    drive_pipe(1, 5'd9, 64'hBB);
    sample();
    check("kill_pipe_waddr", reg_waddr_o, 9);
    tick();
    drive_pipe(0, 0, 0);
    sample();
    check("kill_pop_count", lq_count_o, 1);
    check("kill_pop_wen", reg_wen_o, 0);
    tick();
    drive_lq(1, 5'd0, 64'h55);
    sample();
    tick();
    drive_lq(0, 0, 0);
    sample();
    check("x0_count", lq_count_o, 1);
    check("x0_wen", reg_wen_o, 0);
    tick();
    sample();
    check("x0_count0", lq_count_o, 0);
    check("kill_rf_x9", dut_rf[9], 64'hBB);
    check("x0_rf", dut_rf[0], 0);
    tick();

    // Full FIFO with a held fifth result
    drive_pipe(1, 5'd1, 64'h2);
    for (int i = 0; i < DEPTH; i++) begin
      drive_lq(1, 5'(10 + i), 64'(64'h100 + i));
      sample();
      tick();
    end
    drive_lq(1, 5'd14, 64'h104);
    for (int i = 0; i < 2; i++) begin
      sample();
      check("full_ready", lq_ready_o, 0);
      check("full_count", lq_count_o, DEPTH);
      tick();
    end
    drive_pipe(0, 0, 0);
    sample();
    check("full_first_drain", reg_waddr_o, 10);
    check("full_no_push", lq_count_o, DEPTH);
    tick();
    sample();
    check("full_ready_again", lq_ready_o, 1);
    check("full_second_drain", reg_waddr_o, 11);
    tick();
    drive_lq(0, 0, 0);
    drained = 0;
    for (int i = 0; i < 20 && !drained; i++) begin
      sample();
      if (lq_count_o == 0) drained = 1;
      tick();
    end
    check("full_drained", drained, 1);
    for (int i = 0; i < 5; i++) check("full_rf", dut_rf[10 + i], 64'(64'h100 + i));

    // Starvation
    drive_pipe(1, 5'd2, 64'h3);
    drive_lq(1, 5'd20, 64'hC0DE);
    sample();
    tick();
    drive_lq(0, 0, 0);
    first_stall  = -1;
    stall_cycles = 0;
    for (int k = 1; k <= 30; k++) begin
      sample();
      if (pipe_stall_o) begin
        stall_cycles++;
        if (first_stall < 0) first_stall = k;
        check("force_waddr", reg_waddr_o, 20);
        check("force_wdata", reg_wdata_o, 64'hC0DE);
        check("force_wen", reg_wen_o, 1);
      end
      if (first_stall >= 0 && k == first_stall + 1) begin
        check("resume_stall", pipe_stall_o, 0);
        check("resume_waddr", reg_waddr_o, 2);
      end
      tick();
    end
`ifdef WB_ARB_STARVE_EN
    check("force_cycle", first_stall, STARVE_LIMIT + 1);
    check("force_len", stall_cycles, 1);
    check("force_rf", dut_rf[20], 64'hC0DE);
`else
    check("starve_no_stall", stall_cycles, 0);
    check("starve_not_written", dut_rf[20], 0);
`endif
    drive_pipe(0, 0, 0);
    sample();
    tick();
    sample();
    check("starve_count0", lq_count_o, 0);
    check("starve_rf", dut_rf[20], 64'hC0DE);
    tick();

    // Reset mid-operation discards queued results
    drive_pipe(1, 5'd1, 64'h4);
    drive_lq(1, 5'd21, 64'hD1);
    sample();
    tick();
    drive_lq(1, 5'd22, 64'hD2);
    sample();
    tick();
    drive_lq(0, 0, 0);
    rst = 1'b1;
    sample();
    check("midrst_wen", reg_wen_o, 0);
    tick();
    rst = 1'b0;
    drive_pipe(0, 0, 0);
    sample();
    check("midrst_count", lq_count_o, 0);
    check("midrst_wen2", reg_wen_o, 0);
    tick();
    sample();
    check("midrst_rf21", dut_rf[21], 0);
    check("midrst_rf22", dut_rf[22], 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
